// File: rtl/scaler_line_sink_if.sv
// ----------------------------------------------------------------------------
// scaler_line_sink_if
// Pixel beat stream feeding the line sink. There is no backpressure, so the
// bus carries only a valid strobe and the packed pixel word.
//   valid : beat valid
//   pixel : DATA_W bits of packed pixels
// Modports: master (stream source), slave (line sink).
// ----------------------------------------------------------------------------
interface scaler_line_sink_if #(
    parameter int DATA_W = 16
);
    logic              valid;
    logic [DATA_W-1:0] pixel;

    modport master (output valid, output pixel);
    modport slave  (input  valid, input  pixel);
endinterface

// File: rtl/scaler_line_sink.sv
// ----------------------------------------------------------------------------
// scaler_line_sink
// Captures one video line per start pulse into one of two line-buffer banks.
// Each accepted beat is written one cycle later at an address equal to its
// index within the line. Once a line is complete, the bank is marked full and
// the next line targets the other bank. The downstream reader frees a bank
// with bank_release.
//
// Ports
//   s_clk, s_rst  : clock, asynchronous active-high reset
//   start, len    : arm capture of one line of len beats
//   s_axis        : pixel beat stream (slave modport, no backpressure)
//   bank_release  : per-bank pulse, reader has emptied that bank
//   wr_en/wr_bank/wr_addr/wr_data : line-buffer write port
//   line_done, line_bank : one-cycle completion pulse and its bank
//   bank_full     : per-bank occupancy
//   busy          : FSM not idle
//   err           : sticky {stray_beat, start_nobuf, start_busy}
// ----------------------------------------------------------------------------
module scaler_line_sink #(
    parameter int PIXEL_BITWIDTH = 8,
    parameter int PIXEL_NUM      = 2,
    parameter int IMG_H_MAX      = 3840,
    parameter int IMG_H_BITWIDTH = $clog2(IMG_H_MAX)
) (
    input  logic                                s_clk,
    input  logic                                s_rst,
    input  logic                                start,
    input  logic [IMG_H_BITWIDTH-1:0]           len,
    scaler_line_sink_if.slave                   s_axis,
    input  logic [1:0]                          bank_release,
    output logic                                wr_en,
    output logic                                wr_bank,
    output logic [IMG_H_BITWIDTH-1:0]           wr_addr,
    output logic [PIXEL_BITWIDTH*PIXEL_NUM-1:0] wr_data,
    output logic                                line_done,
    output logic                                line_bank,
    output logic [1:0]                          bank_full,
    output logic                                busy,
    output logic [2:0]                          err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                state;
    logic                      cur_bank;
    logic [IMG_H_BITWIDTH-1:0] cnt;
    logic [IMG_H_BITWIDTH-1:0] len_q;
    logic [1:0]                full_set;

    // Bank being completed this cycle; applied after the release mask so a
    // release that coincides with completion of the same bank loses.
    always_comb begin
        full_set = '0;
        if (state == ST_DONE) begin
            full_set = cur_bank ? 2'b10 : 2'b01;
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state     <= ST_IDLE;
            cur_bank  <= 1'b0;
            cnt       <= '0;
            len_q     <= '0;
            wr_en     <= 1'b0;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            line_done <= 1'b0;
            line_bank <= 1'b0;
            bank_full <= '0;
            err       <= '0;
        end else begin
            wr_en     <= 1'b0;
            line_done <= 1'b0;
            wr_data   <= s_axis.pixel;
            bank_full <= (bank_full & ~bank_release) | full_set;

            case (state)
                ST_IDLE: begin
                    if (s_axis.valid) begin
                        err[2] <= 1'b1;
                    end
                    if (start && (len != '0)) begin
                        if (bank_full[cur_bank]) begin
                            err[1] <= 1'b1;
                        end else begin
                            len_q <= len;
                            cnt   <= '0;
                            state <= ST_RECV;
                        end
                    end
                end

                ST_RECV: begin
                    if (start) begin
                        err[0] <= 1'b1;
                    end
                    if (s_axis.valid) begin
                        wr_en   <= 1'b1;
                        wr_bank <= cur_bank;
                        wr_addr <= cnt;
                        cnt     <= cnt + 1'b1;
                        if (cnt == len_q - 1'b1) begin
                            state <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    if (start) begin
                        err[0] <= 1'b1;
                    end
                    if (s_axis.valid) begin
                        err[2] <= 1'b1;
                    end
                    line_done <= 1'b1;
                    line_bank <= cur_bank;
                    cur_bank  <= ~cur_bank;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scaler_line_sink.sv
// ----------------------------------------------------------------------------
// tb_scaler_line_sink
// Drives lines into scaler_line_sink and checks every write, every line
// completion, and the occupancy/error status against a transaction-level
// model of the two-bank line buffer.
// ----------------------------------------------------------------------------
module tb_scaler_line_sink;

    localparam int PB   = 8;
    localparam int PN   = 2;
    localparam int HMAX = 3840;
    localparam int HW   = $clog2(HMAX);
    localparam int DW   = PB * PN;

    logic          s_clk = 1'b0;
    logic          s_rst;
    logic          start;
    logic [HW-1:0] len;
    logic [1:0]    bank_release;
    logic          wr_en;
    logic          wr_bank;
    logic [HW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          line_done;
    logic          line_bank;
    logic [1:0]    bank_full;
    logic          busy;
    logic [2:0]    err;

    scaler_line_sink_if #(.DATA_W(DW)) s_axis ();

    scaler_line_sink #(
        .PIXEL_BITWIDTH (PB),
        .PIXEL_NUM      (PN),
        .IMG_H_MAX      (HMAX),
        .IMG_H_BITWIDTH (HW)
    ) dut (
        .s_clk        (s_clk),
        .s_rst        (s_rst),
        .start        (start),
        .len          (len),
        .s_axis       (s_axis),
        .bank_release (bank_release),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .line_done    (line_done),
        .line_bank    (line_bank),
        .bank_full    (bank_full),
        .busy         (busy),
        .err          (err)
    );

    always #5 s_clk = ~s_clk;

    typedef struct {
        bit            bank;
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wr_q[$];
    bit  done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cyc = -100;

    // Model of the buffer: which banks hold a line, which bank the next
    // line goes to, and the sticky error flags.
    bit       mdl_full[2];
    bit       mdl_bank;
    bit [2:0] mdl_err;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    // Monitor / scoreboard
    wr_t mon_e;
    bit  mon_b;
    always @(negedge s_clk) begin
        if (!s_rst) begin
            cyc++;
            if (wr_en === 1'b1) begin
                check("write_expected", 64'(wr_q.size() > 0), 64'd1);
                if (wr_q.size() > 0) begin
                    mon_e = wr_q.pop_front();
                    check("wr_bank", 64'(wr_bank), 64'(mon_e.bank));
                    check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                    check("wr_data", 64'(wr_data), 64'(mon_e.data));
                end
                last_wr_cyc = cyc;
            end
            if (line_done === 1'b1) begin
                check("done_expected", 64'(done_q.size() > 0), 64'd1);
                if (done_q.size() > 0) begin
                    mon_b = done_q.pop_front();
                    check("line_bank", 64'(line_bank), 64'(mon_b));
                end
                check("done_latency", 64'(cyc - last_wr_cyc), 64'd1);
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_wr_en"},     64'(wr_en),     64'd0);
        check({tag, "_wr_bank"},   64'(wr_bank),   64'd0);
        check({tag, "_wr_addr"},   64'(wr_addr),   64'd0);
        check({tag, "_wr_data"},   64'(wr_data),   64'd0);
        check({tag, "_line_done"}, 64'(line_done), 64'd0);
        check({tag, "_line_bank"}, 64'(line_bank), 64'd0);
        check({tag, "_bank_full"}, 64'(bank_full), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_err"},       64'(err),       64'd0);
    endtask

    task automatic model_reset();
        mdl_full[0] = 1'b0;
        mdl_full[1] = 1'b0;
        mdl_bank    = 1'b0;
        mdl_err     = '0;
    endtask

    task automatic do_reset(string tag);
        s_rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        check({tag, "_pending_writes"}, 64'(wr_q.size()), 64'd0);
        check({tag, "_pending_done"},   64'(done_q.size()), 64'd0);
        wr_q.delete();
        done_q.delete();
        tick();
        tick();
        s_rst = 1'b0;
        model_reset();
    endtask

    // One idle cycle, then compare status against the model.
    task automatic checkpoint(string tag);
        tick();
        check({tag, "_bank_full"}, 64'(bank_full), 64'({mdl_full[1], mdl_full[0]}));
        check({tag, "_err"},       64'(err),       64'(mdl_err));
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_wr_left"},   64'(wr_q.size()), 64'd0);
        check({tag, "_done_left"}, 64'(done_q.size()), 64'd0);
    endtask

    task automatic release_banks(bit [1:0] mask);
        bank_release = mask;
        tick();
        bank_release = '0;
        if (mask[0]) mdl_full[0] = 1'b0;
        if (mask[1]) mdl_full[1] = 1'b0;
    endtask

    task automatic stray_beat();
        s_axis.valid = 1'b1;
        s_axis.pixel = DW'($urandom);
        tick();
        s_axis.valid = 1'b0;
        mdl_err[2] = 1'b1;
    endtask

    // gap_mode: 0 contiguous, 1 alternate valid/idle, 2 random gaps
    task automatic send_line(int L, int gap_mode, bit rel_done, bit fixed_data, bit start_mid);
        logic [DW-1:0] d;
        start = 1'b1;
        len   = HW'(L);
        tick();
        start = 1'b0;
        if (L == 0) return;
        if (mdl_full[mdl_bank]) begin
            mdl_err[1] = 1'b1;
            for (int i = 0; i < L; i++) stray_beat();
            return;
        end
        for (int i = 0; i < L; i++) begin
            if (gap_mode == 1 && i > 0) tick();
            if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
            d = fixed_data ? DW'((i + 1) * 257) : DW'($urandom);
            s_axis.valid = 1'b1;
            s_axis.pixel = d;
            if (start_mid && i == 1) begin
                start = 1'b1;
                len   = HW'(L + 3);
                mdl_err[0] = 1'b1;
            end
            wr_q.push_back('{bank: mdl_bank, addr: i, data: d});
            tick();
            start = 1'b0;
            s_axis.valid = 1'b0;
        end
        bank_release = rel_done ? (mdl_bank ? 2'b10 : 2'b01) : 2'b00;
        tick();
        bank_release = '0;
        done_q.push_back(mdl_bank);
        mdl_full[mdl_bank] = 1'b1;
        mdl_bank = ~mdl_bank;
    endtask

    initial begin
        s_rst        = 1'b1;
        start        = 1'b0;
        len          = '0;
        bank_release = '0;
        s_axis.valid = 1'b0;
        s_axis.pixel = '0;
        model_reset();
        #2;
        do_reset("por");

        // Basic line into bank 0 with known data
        send_line(4, 0, 1'b0, 1'b1, 1'b0);
        checkpoint("basic");

        // Reset mid-line after 2 of 6 beats
        start = 1'b1;
        len   = HW'(6);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_axis.valid = 1'b1;
            s_axis.pixel = DW'($urandom);
            wr_q.push_back('{bank: mdl_bank, addr: i, data: s_axis.pixel});
            tick();
        end
        s_axis.valid = 1'b0;
        tick();
        do_reset("midline");

        // Two lines back to back, then a start with no free bank
        send_line(3, 0, 1'b0, 1'b0, 1'b0);
        send_line(3, 0, 1'b0, 1'b0, 1'b0);
        checkpoint("two_lines");
        send_line(3, 0, 1'b0, 1'b0, 1'b0);
        checkpoint("nobuf");
        release_banks(2'b01);
        send_line(3, 0, 1'b0, 1'b0, 1'b0);
        checkpoint("after_release");

        // Release of a bank coinciding with its completion
        release_banks(2'b10);
        send_line(2, 0, 1'b1, 1'b0, 1'b0);
        checkpoint("release_race");

        // Alternating valid
        release_banks(2'b11);
        send_line(5, 1, 1'b0, 1'b0, 1'b0);
        checkpoint("toggle_valid");

        // Stray beat in idle and start during a line
        do_reset("pre_err");
        stray_beat();
        send_line(4, 0, 1'b0, 1'b0, 1'b1);
        checkpoint("err_flags");

        // Randomized traffic
        for (int n = 0; n < 25; n++) begin
            int L;
            if ($urandom_range(0, 3) == 0) stray_beat();
            if ($urandom_range(0, 2) == 0) release_banks(2'($urandom_range(1, 3)));
            L = $urandom_range(0, 8);
            send_line(L, $urandom_range(0, 1) * 2, 1'($urandom_range(0, 1)), 1'b0,
                      (L >= 2) ? 1'($urandom_range(0, 3) == 0) : 1'b0);
            checkpoint("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
